wave_sweep_ctrl: RTL and testbench

WAVE_SWEEP_CTRL -- requirements
Module: wave_sweep_ctrl

---
 rtl/wave_sweep_ctrl_if.sv | 51 +++++
 rtl/wave_sweep_ctrl.sv | 170 +++++++++++++++++
 tb/tb_wave_sweep_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/wave_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// wave_sweep_ctrl_if
// Groups the sweep request/configuration inputs and the phase/status outputs
// of wave_sweep_ctrl into one bundle.
//   master : drives start, abort, ftw_start, ftw_step, step_len, num_steps
//            (and loop_en when WAVE_SWEEP_LOOP_EN is defined); observes the
//            outputs.
//   slave  : the sweep controller itself.
// Signals:
//   start, abort        sweep request / terminate
//   ftw_start, ftw_step initial tuning word and per-step increment (ACC_W bits)
//   step_len            dwell cycles per step (16 bits)
//   num_steps           steps per sweep (8 bits)
//   phase               accumulator MSB byte for the waveform LUTs
//   busy, done          running flag, one-cycle completion pulse
//   step_idx            current 0-based step index
// Optional macro: WAVE_SWEEP_LOOP_EN adds loop_en (continuous sweep repeat).
// -----------------------------------------------------------------------------
interface wave_sweep_ctrl_if #(
  parameter int ACC_W = 16
);
  logic             start;
  logic             abort;
  logic [ACC_W-1:0] ftw_start;
  logic [ACC_W-1:0] ftw_step;
  logic [15:0]      step_len;
  logic [7:0]       num_steps;
`ifdef WAVE_SWEEP_LOOP_EN
  logic             loop_en;
`endif
  logic [7:0]       phase;
  logic             busy;
  logic             done;
  logic [7:0]       step_idx;

  modport master (
    output start, abort, ftw_start, ftw_step, step_len, num_steps,
`ifdef WAVE_SWEEP_LOOP_EN
    output loop_en,
`endif
    input  phase, busy, done, step_idx
  );

  modport slave (
    input  start, abort, ftw_start, ftw_step, step_len, num_steps,
`ifdef WAVE_SWEEP_LOOP_EN
    input  loop_en,
`endif
    output phase, busy, done, step_idx
  );
endinterface

// File: rtl/wave_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// wave_sweep_ctrl
// Stepped-frequency sweep controller driving a phase accumulator. On start the
// configuration is latched; the accumulator then advances by the current
// tuning word every cycle, and after every dwell period the tuning word is
// raised by ftw_step (saturating). After the last step a one-cycle done pulse
// is issued and the block returns to idle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : wave_sweep_ctrl_if.slave (request/config inputs, phase/status out)
// Optional macro: WAVE_SWEEP_LOOP_EN -- when defined, bus.loop_en=1 at the
// final step boundary restarts the sweep seamlessly (done still pulses, busy
// stays high, accumulator keeps running). Undefined: same as loop_en=0.
// -----------------------------------------------------------------------------
module wave_sweep_ctrl #(
  parameter int ACC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  wave_sweep_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic [ACC_W-1:0] ftw_start_q, ftw_start_d;
  logic [ACC_W-1:0] ftw_step_q, ftw_step_d;
  logic [15:0]      len_q, len_d;      // effective dwell, never 0
  logic [7:0]       steps_q, steps_d;  // effective step count, never 0
  logic [15:0]      dwell_q, dwell_d;
  logic [7:0]       step_idx_q, step_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             loop_en;
  logic [ACC_W:0]   ftw_sum;
  logic [ACC_W-1:0] ftw_next;
  logic             last_dwell;
  logic             last_step;

`ifdef WAVE_SWEEP_LOOP_EN
  assign loop_en = bus.loop_en;
`else
  assign loop_en = 1'b0;
`endif

  // Carry out of the widened sum means the tuning word overflowed: clamp.
  assign ftw_sum    = {1'b0, ftw_q} + {1'b0, ftw_step_q};
  assign ftw_next   = ftw_sum[ACC_W] ? {ACC_W{1'b1}} : ftw_sum[ACC_W-1:0];
  assign last_dwell = (dwell_q == len_q - 16'd1);
  assign last_step  = (step_idx_q == steps_q - 8'd1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    acc_d       = acc_q;
    ftw_d       = ftw_q;
    ftw_start_d = ftw_start_q;
    ftw_step_d  = ftw_step_q;
    len_d       = len_q;
    steps_d     = steps_q;
    dwell_d     = dwell_q;
    step_idx_d  = step_idx_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        acc_d      = '0;
        dwell_d    = '0;
        step_idx_d = '0;
        if (bus.start && !bus.abort) begin
          ftw_start_d = bus.ftw_start;
          ftw_step_d  = bus.ftw_step;
          ftw_d       = bus.ftw_start;
          len_d       = (bus.step_len == 16'd0) ? 16'd1 : bus.step_len;
          steps_d     = (bus.num_steps == 8'd0) ? 8'd1 : bus.num_steps;
          state_d     = ST_RUN;
          busy_d      = 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          state_d    = ST_IDLE;
          acc_d      = '0;
          dwell_d    = '0;
          step_idx_d = '0;
        end else begin
          acc_d  = acc_q + ftw_q;  // modulo 2^ACC_W wrap is the phase rollover
          busy_d = 1'b1;
          if (last_dwell) begin
            dwell_d = '0;
            if (!last_step) begin
              step_idx_d = step_idx_q + 8'd1;
              ftw_d      = ftw_next;
            end else if (loop_en) begin
              // Seamless restart: accumulator keeps running from where it is.
              ftw_d      = ftw_start_q;
              step_idx_d = '0;
              done_d     = 1'b1;
            end else begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 16'd1;
          end
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        acc_d      = '0;
        dwell_d    = '0;
        step_idx_d = '0;
      end

      default: begin
        state_d    = ST_IDLE;
        acc_d      = '0;
        dwell_d    = '0;
        step_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ftw_q       <= '0;
      ftw_start_q <= '0;
      ftw_step_q  <= '0;
      len_q       <= 16'd1;
      steps_q     <= 8'd1;
      dwell_q     <= '0;
      step_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ftw_q       <= ftw_d;
      ftw_start_q <= ftw_start_d;
      ftw_step_q  <= ftw_step_d;
      len_q       <= len_d;
      steps_q     <= steps_d;
      dwell_q     <= dwell_d;
      step_idx_q  <= step_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.phase    = acc_q[ACC_W-1:ACC_W-8];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_idx = step_idx_q;

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wave_sweep_ctrl
// Directed-vector bench for wave_sweep_ctrl. The stimulus thread pushes the
// expected per-cycle outputs of each sweep into a queue before starting it; a
// monitor pops one entry on every cycle the DUT shows busy or done and
// compares. Idle-state expectations are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_wave_sweep_ctrl;

  localparam int ACC_W = 16;

  typedef struct {
    logic [7:0] phase;
    logic [7:0] idx;
    logic       busy;
    logic       done;
    logic       full;  // 0: only busy/done are meaningful (DONE cycle)
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   total;
  int   bad;

  wave_sweep_ctrl_if #(.ACC_W(ACC_W)) bus ();

  wave_sweep_ctrl #(.ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic push(input logic [7:0] ph, input logic [7:0] idx,
                      input logic b, input logic d, input logic full);
    exp_t e;
    e.phase = ph; e.idx = idx; e.busy = b; e.done = d; e.full = full;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    push(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // Presents a configuration with start high for one sampling edge; returns
  // in the first RUN cycle.
  task automatic start_pulse(input logic [15:0] fs, input logic [15:0] fstep,
                             input logic [15:0] len, input logic [7:0] n);
    bus.ftw_start = fs;
    bus.ftw_step  = fstep;
    bus.step_len  = len;
    bus.num_steps = n;
    bus.start     = 1'b1;
    do_cycle();
    bus.start     = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check(name, {bus.phase, bus.step_idx, 6'd0, bus.busy, bus.done}, 32'd0);
  endtask

  // Monitor: one expected entry per cycle in which busy or done is shown.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1 || bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, bus.busy, bus.done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.full)
            check("run_cycle", {bus.phase, bus.step_idx, 6'd0, bus.busy, bus.done},
                  {e.phase, e.idx, 6'd0, e.busy, e.done});
          else
            check("done_cycle", {30'd0, bus.busy, bus.done}, {30'd0, e.busy, e.done});
        end
      end
    end
  end

  initial begin
    logic [7:0] ph32 [12];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.ftw_start = '0; bus.ftw_step = '0; bus.step_len = '0; bus.num_steps = '0;
`ifdef WAVE_SWEEP_LOOP_EN
    bus.loop_en = 1'b0;
`endif
    wait_cycles(2);
    rst = 1'b0;
    check_idle("reset_state");

    // Basic sweep: three steps of four cycles, start re-pulsed mid-run with
    // different settings must have no effect.
    ph32 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd15, 8'd18, 8'd21};
    for (int i = 0; i < 12; i++) push(ph32[i], 8'(i / 4), 1'b1, 1'b0, 1'b1);
    push_done();
    start_pulse(16'h0100, 16'h0100, 16'd4, 8'd3);
    do_cycle();
    bus.start = 1'b1; bus.ftw_start = 16'hAAAA; bus.ftw_step = 16'h1234;
    bus.step_len = 16'd1; bus.num_steps = 8'd9;
    do_cycle();
    bus.start = 1'b0;
    wait_cycles(10);  // DONE cycle
    do_cycle();
    check_idle("idle_after_sweep");
    wait_cycles(2);
    check_idle("no_restart");

    // Tuning-word saturation and accumulator wrap.
    push(8'h00, 8'd0, 1'b1, 1'b0, 1'b1);
    push(8'hFF, 8'd1, 1'b1, 1'b0, 1'b1);
    push(8'hFE, 8'd2, 1'b1, 1'b0, 1'b1);
    push_done();
    start_pulse(16'hFF00, 16'h0200, 16'd1, 8'd3);
    wait_cycles(4);
    check_idle("idle_after_sat");

    // Zero length/steps behave as one: one RUN cycle then done.
    push(8'h00, 8'd0, 1'b1, 1'b0, 1'b1);
    push_done();
    start_pulse(16'h1000, 16'h1000, 16'd0, 8'd0);
    wait_cycles(2);
    check_idle("idle_after_zero");

    // Abort during cycle 5 of 12.
    for (int i = 0; i < 5; i++) push(ph32[i], 8'(i / 4), 1'b1, 1'b0, 1'b1);
    start_pulse(16'h0100, 16'h0100, 16'd4, 8'd3);
    wait_cycles(4);
    bus.abort = 1'b1;
    do_cycle();
    bus.abort = 1'b0;
    check_idle("after_abort");
    wait_cycles(10);
    check_idle("abort_no_done");

    // Synchronous reset in the middle of a sweep.
    for (int i = 0; i < 3; i++) push(ph32[i], 8'd0, 1'b1, 1'b0, 1'b1);
    start_pulse(16'h0100, 16'h0100, 16'd4, 8'd3);
    wait_cycles(2);
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    check_idle("after_rst");
    wait_cycles(3);
    check_idle("rst_no_done");

    // start and abort together in IDLE: abort wins.
    bus.start = 1'b1; bus.abort = 1'b1;
    do_cycle();
    check_idle("start_abort_idle");
    bus.start = 1'b0; bus.abort = 1'b0;
    wait_cycles(2);
    check_idle("start_abort_stay");

`ifdef WAVE_SWEEP_LOOP_EN
    // Looping: done every 4 cycles with busy held, ftw back to start value;
    // clearing loop_en ends after the current sweep.
    bus.loop_en = 1'b1;
    push(8'd0,  8'd0, 1'b1, 1'b0, 1'b1);
    push(8'd4,  8'd0, 1'b1, 1'b0, 1'b1);
    push(8'd8,  8'd1, 1'b1, 1'b0, 1'b1);
    push(8'd16, 8'd1, 1'b1, 1'b0, 1'b1);
    push(8'd24, 8'd0, 1'b1, 1'b1, 1'b1);
    push(8'd28, 8'd0, 1'b1, 1'b0, 1'b1);
    push(8'd32, 8'd1, 1'b1, 1'b0, 1'b1);
    push(8'd40, 8'd1, 1'b1, 1'b0, 1'b1);
    push_done();
    start_pulse(16'h0400, 16'h0400, 16'd2, 8'd2);
    wait_cycles(5);
    bus.loop_en = 1'b0;
    wait_cycles(4);
    check_idle("idle_after_loop");
`endif

    wait_cycles(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
